ttt_game_ctrl: RTL and testbench
================================

Name: ttt_game_ctrl

Overview:
- Parametrised successor of the 3x3 game-state block: an NxN board with a K-in-a-row win rule.
- Registers moves from the keypad decoder and alternates turns between P1 (X) and P2 (O).
- After each legal move, detects wins and draws with a sequential line walk through the placed cell.
- Drives the 8-digit multiplexed 7-segment display; sits between the key decoder / main-menu logic and the dot-matrix renderer, which reads board_o.

Parameters:
N, 3, board side length (3..8); cell index is row-major, idx = row*N + col.
K, 3, stones in a line needed to win (2..N).
SCAN_DIV, 25000, clk cycles per 7-segment digit slot.
CW, 6, cell-index width; must satisfy 2^CW > N*N.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse from main menu: clear board and begin a game
key_valid  in  1  one-cycle strobe: key_idx holds a move request
key_idx  in  CW  requested cell index
busy  out  1  high while a move is being checked; key_valid is ignored while busy
move_ok  out  1  one-cycle pulse: move accepted
move_err  out  1  one-cycle pulse: move rejected
turn_o  out  1  0 = P1/X to move, 1 = P2/O to move
board_o  out  2*N*N  cell i occupies bits [2i+1:2i]; bit 2i+1 = O, bit 2i = X; 00 = empty
result  out  2  00 playing, 01 X wins, 10 O wins, 11 draw
seg_txt  out  7  segments {g,f,e,d,c,b,a}, active-high
seg_com  out  8  digit enables, active-low; digit 0 = 8'b01111111, digit 7 = 8'b11111110

Behaviour:
- Reset (async, rst_n = 0):
  - FSM goes to IDLE; board_o = 0, turn_o = 0, result = 00.
  - busy, move_ok and move_err = 0; seg_com = 8'hFF, seg_txt = 0.
  - Move counter and scan counter = 0.
- FSM states: IDLE, WAIT_KEY, CHECK, DONE.
- start has priority in every state. Next edge: board cleared, turn_o = 0, result = 00, move count = 0, state = WAIT_KEY. A start during CHECK aborts the check.
- WAIT_KEY, on key_valid:
  - If key_idx >= N*N or the cell is occupied: move_err pulses the next cycle; board and turn are unchanged.
  - Otherwise, on the next edge: write the cell (bit 2i if turn_o = 0, else bit 2i+1), increment the move count, pulse move_ok, latch the index, go to CHECK.
- CHECK:
  - busy = 1. Walk 4 directions through the latched cell: horizontal, vertical, diagonal, anti-diagonal.
  - Per direction, step +1 then -1, one cell per clk, counting same-colour neighbours. Stop a side at the board edge, a non-matching cell, or after K-1 steps.
  - Win if 1 + count >= K. Row wrap is never treated as adjacency.
  - Worst-case latency: 8*(K-1) + 1 cycles.
  - On a win: result = 01 (X) or 10 (O), state = DONE.
  - Else if move count = N*N: result = 11, state = DONE. A win on the final move takes priority over a draw.
  - Else: toggle turn_o, state = WAIT_KEY.
- DONE: board frozen; key_valid causes neither move_ok nor move_err; leave only via start.
- IDLE: key_valid ignored; the display is blank (seg_com = 8'hFF).
- Display:
  - Scan counter advances one digit every SCAN_DIV clk.
  - Digits shown per result:
    - 00: "P1" or "P2" per turn_o, digits 0-1 only.
    - 01: "P2  LOSE" on digits 0-7.
    - 10: "P1  LOSE" on digits 0-7.
    - 11: "tIE" on digits 0-2.
  - Unused slots drive seg_com = 8'hFF.
  - Segment codes: P = 1110011, 1 = 0000110, 2 = 1011011, L = 0111000, O = 0111111, S = 1101101, E = 1111001, t = 1111000, I = 0110000, blank = 0000000.
  - The digit index wraps to 0 after the last used digit. When result changes, the index restarts at 0.

Optional Feature:
- Macro: TTT_UNDO_EN.
- Defined:
  - Adds input port undo (1-bit pulse).
  - In WAIT_KEY with move count > 0 and an undo slot available: the next edge clears the last-placed cell, decrements the move count, toggles turn_o back, and pulses move_ok.
  - One level only: a second undo is ignored until a new move is accepted.
  - Undo is ignored in IDLE, CHECK and DONE.
- Undefined: no port, no history register.

Test Plan:
- N=3, K=3: start; X plays 0, O 3, X 1, O 4, X 2 -> result = 01 within 17 cycles of the last move_ok; turn_o stays 0; seg digit 0 shows 1110011 (P), digit 4 shows 0111000 (L).
- N=3: fill the board with no line, X ending on a full row -> result = 01, not 11; a no-line full board -> result = 11, display "tIE".
- N=5, K=4: X plays cells 4, 8, 12, 16 (anti-diagonal) -> result = 01. X plays 3, 4, 5, 6 (row wrap) -> no win, turn toggles.
- Occupied-cell key and key_idx = 9 on N=3 -> move_err pulses, board_o and turn_o unchanged; key_valid during busy -> ignored.
- start mid-CHECK and rst_n low mid-game -> board_o = 0, result = 00, turn_o = 0; after reset, FSM is in IDLE and ignores keys until start.
- TTT_UNDO_EN: move, undo, undo -> only the last cell is cleared, turn_o restored, the second undo is ignored.

Source files
------------

// File: rtl/ttt_game_ctrl.sv
// NxN K-in-a-row game controller: move registration, line-walk win/draw check, 7-seg status display.
// Optional single-level undo of the last placed stone when TTT_UNDO_EN is defined.
module ttt_game_ctrl #(
    parameter int N        = 3,
    parameter int K        = 3,
    parameter int SCAN_DIV = 25000,
    parameter int CW       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              key_valid,
    input  logic [CW-1:0]     key_idx,
`ifdef TTT_UNDO_EN
    input  logic              undo,
`endif
    output logic              busy,
    output logic              move_ok,
    output logic              move_err,
    output logic              turn_o,
    output logic [2*N*N-1:0]  board_o,
    output logic [1:0]        result,
    output logic [6:0]        seg_txt,
    output logic [7:0]        seg_com
);

    localparam int BW = 2 * N * N;
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CELLS = CW'(N * N);

    localparam logic [6:0] G_P  = 7'b1110011;
    localparam logic [6:0] G_1  = 7'b0000110;
    localparam logic [6:0] G_2  = 7'b1011011;
    localparam logic [6:0] G_L  = 7'b0111000;
    localparam logic [6:0] G_O  = 7'b0111111;
    localparam logic [6:0] G_S  = 7'b1101101;
    localparam logic [6:0] G_E  = 7'b1111001;
    localparam logic [6:0] G_T  = 7'b1111000;
    localparam logic [6:0] G_I  = 7'b0110000;
    localparam logic [6:0] G_BL = 7'b0000000;

    typedef enum logic [1:0] {IDLE, WAIT_KEY, CHECK, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    brow, bcol, pr, pc;
    logic [1:0]    dir;
    logic          side;
    logic [3:0]    steps, line;
`ifdef TTT_UNDO_EN
    logic [CW-1:0] last;
    logic          undo_avail;
`endif

    logic [4:0]    krow, kcol;
    logic [7:0]    probe_idx;
    logic [1:0]    key_cell, probe_cell, colour;
    logic          probe_in, probe_hit, side_end, win;
    logic [3:0]    line_inc;
    logic [9:0]    d_cur, d_back, d_next;

    // Row/col steps as 5-bit two's complement; -1 from col 0 lands >= N, i.e. off board.
    function automatic logic [9:0] delta(input logic [1:0] d, input logic neg);
        logic [4:0] dr, dc;
        unique case (d)
            2'd0:    begin dr = 5'd0; dc = 5'd1;  end
            2'd1:    begin dr = 5'd1; dc = 5'd0;  end
            2'd2:    begin dr = 5'd1; dc = 5'd1;  end
            default: begin dr = 5'd1; dc = 5'h1f; end
        endcase
        if (neg) begin
            dr = 5'd0 - dr;
            dc = 5'd0 - dc;
        end
        return {dr, dc};
    endfunction

    assign colour    = turn_o ? 2'b10 : 2'b01;
    assign krow      = 5'(key_idx / CW'(N));
    assign kcol      = 5'(key_idx % CW'(N));
    assign probe_in  = (pr < 5'(N)) && (pc < 5'(N));
    assign probe_idx = 8'(pr) * 8'(N) + 8'(pc);
    assign probe_hit = probe_in && (probe_cell == colour);
    assign line_inc  = line + 4'd1;
    assign win       = probe_hit && (line_inc >= 4'(K - 1));
    assign side_end  = !probe_hit || (steps == 4'(K - 1));
    assign d_cur     = delta(dir, side);
    assign d_back    = delta(dir, 1'b1);
    assign d_next    = delta(dir + 2'd1, 1'b0);

    always_comb begin
        key_cell   = 2'b00;
        probe_cell = 2'b00;
        for (int i = 0; i < N * N; i++) begin
            if (key_idx == CW'(i))
                key_cell = board_o[2*i +: 2];
            if (probe_idx == 8'(i))
                probe_cell = board_o[2*i +: 2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            board_o  <= '0;
            turn_o   <= 1'b0;
            result   <= 2'b00;
            busy     <= 1'b0;
            move_ok  <= 1'b0;
            move_err <= 1'b0;
            cnt      <= '0;
            brow     <= '0;
            bcol     <= '0;
            pr       <= '0;
            pc       <= '0;
            dir      <= '0;
            side     <= 1'b0;
            steps    <= '0;
            line     <= '0;
`ifdef TTT_UNDO_EN
            last       <= '0;
            undo_avail <= 1'b0;
`endif
        end else begin
            move_ok  <= 1'b0;
            move_err <= 1'b0;
            if (start) begin
                state   <= WAIT_KEY;
                board_o <= '0;
                turn_o  <= 1'b0;
                result  <= 2'b00;
                cnt     <= '0;
                busy    <= 1'b0;
`ifdef TTT_UNDO_EN
                undo_avail <= 1'b0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    WAIT_KEY: begin
`ifdef TTT_UNDO_EN
                        if (undo && undo_avail && cnt != '0) begin
                            board_o    <= board_o & ~(BW'(2'b11) << {last, 1'b0});
                            cnt        <= cnt - CW'(1);
                            turn_o     <= !turn_o;
                            move_ok    <= 1'b1;
                            undo_avail <= 1'b0;
                        end else
`endif
                        if (key_valid) begin
                            if (key_idx >= CELLS || key_cell != 2'b00) begin
                                move_err <= 1'b1;
                            end else begin
                                board_o <= board_o | (BW'(colour) << {key_idx, 1'b0});
                                cnt     <= cnt + CW'(1);
                                move_ok <= 1'b1;
                                busy    <= 1'b1;
                                state   <= CHECK;
                                brow    <= krow;
                                bcol    <= kcol;
                                pr      <= krow;
                                pc      <= kcol + 5'd1;
                                dir     <= 2'd0;
                                side    <= 1'b0;
                                steps   <= 4'd1;
                                line    <= 4'd0;
`ifdef TTT_UNDO_EN
                                last       <= key_idx;
                                undo_avail <= 1'b1;
`endif
                            end
                        end
                    end
                    CHECK: begin
                        if (win) begin
                            result <= turn_o ? 2'b10 : 2'b01;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end else if (side_end && side && dir == 2'd3) begin
                            busy <= 1'b0;
                            if (cnt == CELLS) begin
                                result <= 2'b11;
                                state  <= DONE;
                            end else begin
                                turn_o <= !turn_o;
                                state  <= WAIT_KEY;
                            end
                        end else if (side_end && !side) begin
                            side  <= 1'b1;
                            steps <= 4'd1;
                            pr    <= brow + d_back[9:5];
                            pc    <= bcol + d_back[4:0];
                        end else if (side_end) begin
                            dir   <= dir + 2'd1;
                            side  <= 1'b0;
                            steps <= 4'd1;
                            line  <= 4'd0;
                            pr    <= brow + d_next[9:5];
                            pc    <= bcol + d_next[4:0];
                        end else begin
                            line  <= line_inc;
                            steps <= steps + 4'd1;
                            pr    <= pr + d_cur[9:5];
                            pc    <= pc + d_cur[4:0];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    logic [SCW-1:0] scan;
    logic [2:0]     digit, last_dig;
    logic [1:0]     shown;

    always_comb begin
        unique case (result)
            2'b00:   last_dig = 3'd1;
            2'b11:   last_dig = 3'd2;
            default: last_dig = 3'd7;
        endcase
    end

    function automatic logic [6:0] glyph(input logic [1:0] res, input logic t,
                                         input logic [2:0] dig);
        logic [6:0] g;
        g = G_BL;
        unique case (res)
            2'b00: begin
                if (dig == 3'd0)
                    g = G_P;
                else if (dig == 3'd1)
                    g = t ? G_2 : G_1;
            end
            2'b11: begin
                if (dig == 3'd0)
                    g = G_T;
                else if (dig == 3'd1)
                    g = G_I;
                else if (dig == 3'd2)
                    g = G_E;
            end
            default: begin
                unique case (dig)
                    3'd0:    g = G_P;
                    3'd1:    g = (res == 2'b01) ? G_2 : G_1;
                    3'd4:    g = G_L;
                    3'd5:    g = G_O;
                    3'd6:    g = G_S;
                    3'd7:    g = G_E;
                    default: g = G_BL;
                endcase
            end
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan    <= '0;
            digit   <= '0;
            shown   <= 2'b00;
            seg_com <= 8'hFF;
            seg_txt <= 7'd0;
        end else begin
            if (result != shown) begin
                shown <= result;
                scan  <= '0;
                digit <= '0;
            end else if (scan == SCW'(SCAN_DIV - 1)) begin
                scan  <= '0;
                digit <= (digit >= last_dig) ? 3'd0 : digit + 3'd1;
            end else begin
                scan <= scan + SCW'(1);
            end
            if (state == IDLE || digit > last_dig) begin
                seg_com <= 8'hFF;
                seg_txt <= 7'd0;
            end else begin
                seg_com <= ~(8'h80 >> digit);
                seg_txt <= glyph(result, turn_o, digit);
            end
        end
    end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: 3x3/K=3 and 5x5/K=4 instances driven from a vector table.
// Undo sequence is exercised when TTT_UNDO_EN is defined.
module tb_ttt_game_ctrl;

    localparam int CW = 6;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, kv_a, start_b, kv_b;
    logic [CW-1:0] ki_a, ki_b;
`ifdef TTT_UNDO_EN
    logic undo_a, undo_b;
`endif
    logic busy_a, ok_a, err_a, turn_a;
    logic busy_b, ok_b, err_b, turn_b;
    logic [17:0] board_a;
    logic [49:0] board_b;
    logic [1:0] res_a, res_b;
    logic [6:0] txt_a, txt_b;
    logic [7:0] com_a, com_b;

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] mb [2];
    logic mturn [2];

    typedef struct {
        int sel;
        bit is_key;
        int idx;
        logic ok;
        logic err;
        logic turn;
        logic [1:0] res;
    } vec_t;

    always #5 clk = ~clk;

    ttt_game_ctrl #(.N(3), .K(3), .SCAN_DIV(SD), .CW(CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .key_valid(kv_a), .key_idx(ki_a),
`ifdef TTT_UNDO_EN
        .undo(undo_a),
`endif
        .busy(busy_a), .move_ok(ok_a), .move_err(err_a),
        .turn_o(turn_a), .board_o(board_a), .result(res_a),
        .seg_txt(txt_a), .seg_com(com_a)
    );

    ttt_game_ctrl #(.N(5), .K(4), .SCAN_DIV(SD), .CW(CW)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .key_valid(kv_b), .key_idx(ki_b),
`ifdef TTT_UNDO_EN
        .undo(undo_b),
`endif
        .busy(busy_b), .move_ok(ok_b), .move_err(err_b),
        .turn_o(turn_b), .board_o(board_b), .result(res_b),
        .seg_txt(txt_b), .seg_com(com_b)
    );

    function automatic logic [63:0] brd(input int s);
        return (s == 0) ? 64'(board_a) : 64'(board_b);
    endfunction
    function automatic logic [63:0] okv(input int s);
        return (s == 0) ? 64'(ok_a) : 64'(ok_b);
    endfunction
    function automatic logic [63:0] erv(input int s);
        return (s == 0) ? 64'(err_a) : 64'(err_b);
    endfunction
    function automatic logic [63:0] bsy(input int s);
        return (s == 0) ? 64'(busy_a) : 64'(busy_b);
    endfunction
    function automatic logic [63:0] trn(input int s);
        return (s == 0) ? 64'(turn_a) : 64'(turn_b);
    endfunction
    function automatic logic [63:0] rsl(input int s);
        return (s == 0) ? 64'(res_a) : 64'(res_b);
    endfunction
    function automatic logic [63:0] com(input int s);
        return (s == 0) ? 64'(com_a) : 64'(com_b);
    endfunction
    function automatic logic [63:0] txt(input int s);
        return (s == 0) ? 64'(txt_a) : 64'(txt_b);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t vs(input int s);
        vec_t t;
        t.sel = s; t.is_key = 1'b0; t.idx = 0;
        t.ok = 1'b0; t.err = 1'b0; t.turn = 1'b0; t.res = 2'b00;
        return t;
    endfunction

    function automatic vec_t vk(input int s, input int i, input logic o, input logic e,
                                input logic tn, input logic [1:0] r);
        vec_t t;
        t.sel = s; t.is_key = 1'b1; t.idx = i;
        t.ok = o; t.err = e; t.turn = tn; t.res = r;
        return t;
    endfunction

    task automatic drive(input int s, input logic st, input logic kv, input int idx);
        if (s == 0) begin
            start_a = st; kv_a = kv; ki_a = CW'(idx);
        end else begin
            start_b = st; kv_b = kv; ki_b = CW'(idx);
        end
    endtask

    task automatic wait_idle(input int s, output int n);
        n = 0;
        while (bsy(s) != 64'd0 && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        int n;
        int lat;
        lat = (t.sel == 0) ? 17 : 25;
        @(negedge clk);
        drive(t.sel, !t.is_key, t.is_key, t.idx);
        @(negedge clk);
        drive(t.sel, 1'b0, 1'b0, 0);
        if (!t.is_key) begin
            mb[t.sel] = '0;
        end else begin
            chk({tag, "_ok"}, okv(t.sel), 64'(t.ok));
            chk({tag, "_err"}, erv(t.sel), 64'(t.err));
            if (t.ok) begin
                chk({tag, "_busy"}, bsy(t.sel), 64'd1);
                mb[t.sel] = mb[t.sel] | ((mturn[t.sel] ? 64'd2 : 64'd1) << (2 * t.idx));
            end
        end
        wait_idle(t.sel, n);
        if (t.is_key && t.ok)
            chk({tag, "_latency"}, 64'(n <= lat), 64'd1);
        chk({tag, "_turn"}, trn(t.sel), 64'(t.turn));
        chk({tag, "_result"}, rsl(t.sel), 64'(t.res));
        chk({tag, "_board"}, brd(t.sel), mb[t.sel]);
        mturn[t.sel] = t.turn;
    endtask

    task automatic see(input int s, input int dig, input logic [6:0] exp, input string tag);
        logic [7:0] want;
        int n;
        want = ~(8'h80 >> dig);
        n = 0;
        while (com(s) != 64'(want) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_com"}, com(s), 64'(want));
        chk({tag, "_txt"}, txt(s), 64'(exp));
    endtask

    initial begin
        vec_t v[$];
        int n;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 0);
        drive(1, 1'b0, 1'b0, 0);
`ifdef TTT_UNDO_EN
        undo_a = 1'b0;
        undo_b = 1'b0;
`endif
        mb[0] = '0; mb[1] = '0;
        mturn[0] = 1'b0; mturn[1] = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst%0d_board", s), brd(s), 64'd0);
            chk($sformatf("rst%0d_turn", s), trn(s), 64'd0);
            chk($sformatf("rst%0d_result", s), rsl(s), 64'd0);
            chk($sformatf("rst%0d_busy", s), bsy(s), 64'd0);
            chk($sformatf("rst%0d_ok", s), okv(s), 64'd0);
            chk($sformatf("rst%0d_com", s), com(s), 64'hFF);
            chk($sformatf("rst%0d_txt", s), txt(s), 64'd0);
        end
        rst_n = 1'b1;
        apply(vk(0, 0, 0, 0, 0, 2'b00), "idle_key");

        // 3x3: X wins on row 0, then a key in DONE
        v.push_back(vs(0));
        v.push_back(vk(0, 0, 1, 0, 1, 2'b00));
        v.push_back(vk(0, 3, 1, 0, 0, 2'b00));
        v.push_back(vk(0, 1, 1, 0, 1, 2'b00));
        v.push_back(vk(0, 4, 1, 0, 0, 2'b00));
        v.push_back(vk(0, 2, 1, 0, 0, 2'b01));
        v.push_back(vk(0, 5, 0, 0, 0, 2'b01));
        // illegal moves
        v.push_back(vs(0));
        v.push_back(vk(0, 9, 0, 1, 0, 2'b00));
        v.push_back(vk(0, 4, 1, 0, 1, 2'b00));
        v.push_back(vk(0, 4, 0, 1, 1, 2'b00));
        // full board, final X completes row 0: win beats draw
        v.push_back(vs(0));
        v.push_back(vk(0, 0, 1, 0, 1, 2'b00));
        v.push_back(vk(0, 4, 1, 0, 0, 2'b00));
        v.push_back(vk(0, 5, 1, 0, 1, 2'b00));
        v.push_back(vk(0, 3, 1, 0, 0, 2'b00));
        v.push_back(vk(0, 6, 1, 0, 1, 2'b00));
        v.push_back(vk(0, 7, 1, 0, 0, 2'b00));
        v.push_back(vk(0, 1, 1, 0, 1, 2'b00));
        v.push_back(vk(0, 8, 1, 0, 0, 2'b00));
        v.push_back(vk(0, 2, 1, 0, 0, 2'b01));
        // full board, no line: draw
        v.push_back(vs(0));
        v.push_back(vk(0, 0, 1, 0, 1, 2'b00));
        v.push_back(vk(0, 1, 1, 0, 0, 2'b00));
        v.push_back(vk(0, 2, 1, 0, 1, 2'b00));
        v.push_back(vk(0, 4, 1, 0, 0, 2'b00));
        v.push_back(vk(0, 3, 1, 0, 1, 2'b00));
        v.push_back(vk(0, 5, 1, 0, 0, 2'b00));
        v.push_back(vk(0, 7, 1, 0, 1, 2'b00));
        v.push_back(vk(0, 6, 1, 0, 0, 2'b00));
        v.push_back(vk(0, 8, 1, 0, 0, 2'b11));
        // 5x5 K=4: anti-diagonal win
        v.push_back(vs(1));
        v.push_back(vk(1, 4, 1, 0, 1, 2'b00));
        v.push_back(vk(1, 0, 1, 0, 0, 2'b00));
        v.push_back(vk(1, 8, 1, 0, 1, 2'b00));
        v.push_back(vk(1, 1, 1, 0, 0, 2'b00));
        v.push_back(vk(1, 12, 1, 0, 1, 2'b00));
        v.push_back(vk(1, 2, 1, 0, 0, 2'b00));
        v.push_back(vk(1, 16, 1, 0, 0, 2'b01));
        // 5x5: 3,4,5,6 wraps a row and is not a line
        v.push_back(vs(1));
        v.push_back(vk(1, 3, 1, 0, 1, 2'b00));
        v.push_back(vk(1, 10, 1, 0, 0, 2'b00));
        v.push_back(vk(1, 4, 1, 0, 1, 2'b00));
        v.push_back(vk(1, 11, 1, 0, 0, 2'b00));
        v.push_back(vk(1, 5, 1, 0, 1, 2'b00));
        v.push_back(vk(1, 20, 1, 0, 0, 2'b00));
        v.push_back(vk(1, 6, 1, 0, 1, 2'b00));

        for (int i = 0; i < v.size(); i++)
            apply(v[i], $sformatf("v%0d", i));

        see(0, 0, 7'b1111000, "draw_d0");
        see(0, 1, 7'b0110000, "draw_d1");
        see(0, 2, 7'b1111001, "draw_d2");
        see(1, 0, 7'b1110011, "p2_d0");
        see(1, 1, 7'b1011011, "p2_d1");

        // key during busy is dropped
        apply(vs(0), "bz_start");
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0);
        chk("bz_ok", okv(0), 64'd1);
        chk("bz_busy", bsy(0), 64'd1);
        drive(0, 1'b0, 1'b1, 1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0);
        chk("bz_key_ok", okv(0), 64'd0);
        chk("bz_key_err", erv(0), 64'd0);
        wait_idle(0, n);
        chk("bz_board", brd(0), 64'h1);
        chk("bz_turn", trn(0), 64'd1);

        // start aborts a running check
        drive(0, 1'b0, 1'b1, 4);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0);
        chk("ab_busy", bsy(0), 64'd1);
        drive(0, 1'b1, 1'b0, 0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0);
        chk("ab_board", brd(0), 64'd0);
        chk("ab_result", rsl(0), 64'd0);
        chk("ab_turn", trn(0), 64'd0);
        chk("ab_busy_lo", bsy(0), 64'd0);
        mb[0] = '0;
        mturn[0] = 1'b0;
        apply(vk(0, 4, 1, 0, 1, 2'b00), "ab_move");

        // async reset mid-game, then IDLE ignores keys
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_board", brd(0), 64'd0);
        chk("ar_turn", trn(0), 64'd0);
        chk("ar_result", rsl(0), 64'd0);
        chk("ar_com", com(0), 64'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        mb[0] = '0; mb[1] = '0;
        mturn[0] = 1'b0; mturn[1] = 1'b0;
        apply(vk(0, 2, 0, 0, 0, 2'b00), "ar_idle_key");
        repeat (3 * SD) @(negedge clk);
        chk("ar_idle_com", com(0), 64'hFF);

        // X win display: "P2  LOSE"
        apply(vs(0), "w_start");
        apply(vk(0, 0, 1, 0, 1, 2'b00), "w0");
        apply(vk(0, 3, 1, 0, 0, 2'b00), "w1");
        apply(vk(0, 1, 1, 0, 1, 2'b00), "w2");
        apply(vk(0, 4, 1, 0, 0, 2'b00), "w3");
        apply(vk(0, 2, 1, 0, 0, 2'b01), "w4");
        see(0, 0, 7'b1110011, "win_d0");
        see(0, 1, 7'b1011011, "win_d1");
        see(0, 4, 7'b0111000, "win_d4");
        see(0, 7, 7'b1111001, "win_d7");

`ifdef TTT_UNDO_EN
        apply(vs(0), "u_start");
        apply(vk(0, 0, 1, 0, 1, 2'b00), "u0");
        apply(vk(0, 1, 1, 0, 0, 2'b00), "u1");
        @(negedge clk);
        undo_a = 1'b1;
        @(negedge clk);
        undo_a = 1'b0;
        chk("undo1_ok", okv(0), 64'd1);
        chk("undo1_board", brd(0), 64'h1);
        chk("undo1_turn", trn(0), 64'd1);
        @(negedge clk);
        undo_a = 1'b1;
        @(negedge clk);
        undo_a = 1'b0;
        chk("undo2_ok", okv(0), 64'd0);
        chk("undo2_board", brd(0), 64'h1);
        chk("undo2_turn", trn(0), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
